// File: rtl/dtlb.sv
// Data TLB: 16 sets x 8 ways of page-pair translations with zero-latency lookup
// and single-cycle fill using forced, tag-match or round-robin victim selection.
module dtlb #(
  parameter int DATA_WIDTH = 36,
  parameter int IP_WIDTH   = 52
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_clkEn,
  input  logic                  sec_wren,
  input  logic [IP_WIDTH-1:0]   addr,
  input  logic [20:0]           sproc,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] read_data_next,
  output logic [2:0]            read_way,
  output logic                  read_hit,
  input  logic [IP_WIDTH-2:0]   write_addr,
  input  logic [DATA_WIDTH-1:0] write_data0,
  input  logic [DATA_WIDTH-1:0] write_data1,
  input  logic [DATA_WIDTH-1:0] write_data2,
  input  logic [2:0]            force_way,
  input  logic                  force_way_en,
  input  logic                  write_xstant,
  input  logic                  write_invl,
  input  logic                  write_wen
);

  localparam int SETS  = 16;
  localparam int WAYS  = 8;
  localparam int TAG_W = IP_WIDTH - 5;

  logic [WAYS-1:0]       valid_reg [SETS];
  logic [2:0]            ptr_reg   [SETS];
  logic [TAG_W-1:0]      tag_reg   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data0_reg [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data1_reg [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data2_reg [SETS][WAYS];

  // Lookup key: the space modifier is folded into the process field.
  logic [IP_WIDTH-1:0] key;
  logic [3:0]          rd_set;
  logic [TAG_W-1:0]    rd_tag;
  assign key    = {addr[IP_WIDTH-1 -: 21] ^ sproc, addr[IP_WIDTH-22:0]};
  assign rd_set = key[4:1];
  assign rd_tag = key[IP_WIDTH-1:5];

  logic [3:0]       wr_set;
  logic [TAG_W-1:0] wr_tag;
  assign wr_set = write_addr[3:0];
  assign wr_tag = write_addr[IP_WIDTH-2:4];

  logic [WAYS-1:0] rd_match;
  logic [WAYS-1:0] wr_match;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
      assign rd_match[gi] = valid_reg[rd_set][gi] && (tag_reg[rd_set][gi] == rd_tag);
      assign wr_match[gi] = valid_reg[wr_set][gi] && (tag_reg[wr_set][gi] == wr_tag);
    end
  endgenerate

  logic [2:0] rd_way_sel;
  logic       rd_hit;

  always_comb begin
    rd_way_sel = 3'd0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (rd_match[i]) rd_way_sel = 3'(i);
    end
    rd_hit         = read_clkEn & sec_wren & (|rd_match);
    read_hit       = rd_hit;
    read_way       = rd_hit ? rd_way_sel : 3'd0;
    read_data      = '0;
    read_data_next = '0;
    if (rd_hit) begin
      if (addr[0]) begin
        read_data      = data1_reg[rd_set][rd_way_sel];
        read_data_next = data2_reg[rd_set][rd_way_sel];
      end else begin
        read_data      = data0_reg[rd_set][rd_way_sel];
        read_data_next = data1_reg[rd_set][rd_way_sel];
      end
    end
  end

  logic [2:0]      wr_hit_way;
  logic [2:0]      victim;
  logic [WAYS-1:0] victim_onehot;
  logic [WAYS-1:0] wr_valid_next;
  logic            ptr_advance;

  always_comb begin
    wr_hit_way = 3'd0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (wr_match[i]) wr_hit_way = 3'(i);
    end
    if (force_way_en)   victim = force_way;
    else if (|wr_match) victim = wr_hit_way;
    else                victim = ptr_reg[wr_set];
    victim_onehot = WAYS'(1) << victim;
    wr_valid_next = valid_reg[wr_set] | victim_onehot;
    // Duplicates of the same tag elsewhere in the set are dropped on request.
    if (write_invl) wr_valid_next = wr_valid_next & ~(wr_match & ~victim_onehot);
    ptr_advance = (victim == ptr_reg[wr_set]) && !write_xstant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        ptr_reg[s]   <= 3'd0;
      end
    end else if (write_wen) begin
      valid_reg[wr_set] <= wr_valid_next;
      if (ptr_advance) ptr_reg[wr_set] <= ptr_reg[wr_set] + 3'd1;
    end
  end

  // Payload arrays need no reset: a cleared valid bit hides stale contents.
  always_ff @(posedge clk) begin
    if (!rst && write_wen) begin
      tag_reg[wr_set][victim]   <= wr_tag;
      data0_reg[wr_set][victim] <= write_data0;
      data1_reg[wr_set][victim] <= write_data1;
      data2_reg[wr_set][victim] <= write_data2;
    end
  end

endmodule

// File: tb/tb_dtlb.sv
// Directed self-checking bench for dtlb: lookup gating, data selection,
// victim selection, round-robin wrap, invalidation and reset behaviour.
module tb_dtlb;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_clkEn, sec_wren;
  logic [51:0] addr;
  logic [20:0] sproc;
  logic [35:0] read_data, read_data_next;
  logic [2:0]  read_way;
  logic        read_hit;
  logic [50:0] write_addr;
  logic [35:0] write_data0, write_data1, write_data2;
  logic [2:0]  force_way;
  logic        force_way_en, write_xstant, write_invl, write_wen;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [35:0] DA = 36'h1_1111_1111;
  localparam logic [35:0] DB = 36'h2_2222_2222;
  localparam logic [35:0] DC = 36'h3_3333_3333;
  localparam logic [35:0] DD = 36'h4_4444_4444;

  dtlb dut (
    .clk(clk), .rst(rst), .read_clkEn(read_clkEn), .sec_wren(sec_wren),
    .addr(addr), .sproc(sproc), .read_data(read_data),
    .read_data_next(read_data_next), .read_way(read_way), .read_hit(read_hit),
    .write_addr(write_addr), .write_data0(write_data0), .write_data1(write_data1),
    .write_data2(write_data2), .force_way(force_way), .force_way_en(force_way_en),
    .write_xstant(write_xstant), .write_invl(write_invl), .write_wen(write_wen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [51:0] a);
    addr = a;
    #2;
  endtask

  task automatic fill(input logic [50:0] wa, input logic [35:0] d0, input logic [35:0] d1,
                      input logic [35:0] d2, input logic fen, input logic [2:0] fw,
                      input logic xst, input logic inv);
    write_addr = wa; write_data0 = d0; write_data1 = d1; write_data2 = d2;
    force_way_en = fen; force_way = fw; write_xstant = xst; write_invl = inv;
    write_wen = 1'b1;
    tick();
    write_wen = 1'b0; force_way_en = 1'b0; write_xstant = 1'b0; write_invl = 1'b0;
  endtask

  initial begin
    rst = 1'b1; read_clkEn = 1'b1; sec_wren = 1'b1; addr = '0; sproc = '0;
    write_addr = '0; write_data0 = '0; write_data1 = '0; write_data2 = '0;
    force_way = '0; force_way_en = 1'b0; write_xstant = 1'b0; write_invl = 1'b0;
    write_wen = 1'b0;
    tick(); tick();
    rst = 1'b0;

    look(52'h246);
    check("rst_hit", 64'(read_hit), 64'd0);
    check("rst_data", 64'(read_data), 64'd0);
    check("rst_next", 64'(read_data_next), 64'd0);
    check("rst_way", 64'(read_way), 64'd0);

    fill(51'h123, DA, DB, DC, 1'b0, 3'd0, 1'b0, 1'b0);
    look(52'h246);
    check("even_hit", 64'(read_hit), 64'd1);
    check("even_data", 64'(read_data), 64'(DA));
    check("even_next", 64'(read_data_next), 64'(DB));
    look(52'h247);
    check("odd_data", 64'(read_data), 64'(DB));
    check("odd_next", 64'(read_data_next), 64'(DC));
    check("odd_way", 64'(read_way), 64'd0);

    sec_wren = 1'b0; look(52'h246);
    check("sec_block", 64'(read_hit), 64'd0);
    check("sec_data0", 64'(read_data), 64'd0);
    sec_wren = 1'b1; read_clkEn = 1'b0; look(52'h246);
    check("en_block", 64'(read_hit), 64'd0);
    read_clkEn = 1'b1; sproc = 21'd1; look(52'h246);
    check("sproc_miss", 64'(read_hit), 64'd0);
    look(52'h246 ^ (52'd1 << 31));
    check("sproc_hit", 64'(read_hit), 64'd1);
    sproc = '0;

    // Refill same tag: old contents visible during the write cycle, new ones after.
    addr = 52'h246;
    write_addr = 51'h123; write_data0 = DD; write_data1 = DB; write_data2 = DC;
    write_wen = 1'b1;
    #2;
    check("pre_fill_data", 64'(read_data), 64'(DA));
    tick();
    write_wen = 1'b0;
    look(52'h246);
    check("refill_data", 64'(read_data), 64'(DD));
    check("refill_way", 64'(read_way), 64'd0);

    // Nine distinct tags into set 0: ninth wraps to way 0, evicting the first.
    for (int i = 1; i <= 9; i++)
      fill(51'(i) << 4, 36'(i), 36'(i + 100), 36'(i + 200), 1'b0, 3'd0, 1'b0, 1'b0);
    look(52'(1) << 5);
    check("rr_evicted", 64'(read_hit), 64'd0);
    for (int i = 2; i <= 9; i++) begin
      look(52'(i) << 5);
      check($sformatf("rr_hit_%0d", i), 64'(read_hit), 64'd1);
      check($sformatf("rr_way_%0d", i), 64'(read_way), 64'(i % 8 == 1 ? 0 : i - 1));
    end
    look(52'(5) << 5);
    check("rr_data5", 64'(read_data), 64'd5);

    // Forced fill with xstant leaves the pointer at 1.
    fill(51'd10 << 4, DA, DB, DC, 1'b1, 3'd5, 1'b1, 1'b0);
    look(52'd10 << 5);
    check("force_hit", 64'(read_hit), 64'd1);
    check("force_way", 64'(read_way), 64'd5);
    fill(51'd11 << 4, DB, DC, DD, 1'b0, 3'd0, 1'b0, 1'b0);
    look(52'd11 << 5);
    check("ptr_kept_way", 64'(read_way), 64'd1);
    look(52'd2 << 5);
    check("ptr_evict2", 64'(read_hit), 64'd0);

    // Forced duplicate into way 2 with invalidate removes way 0 copy.
    fill(51'h123, DC, DD, DA, 1'b1, 3'd2, 1'b0, 1'b1);
    look(52'h246);
    check("invl_hit", 64'(read_hit), 64'd1);
    check("invl_way", 64'(read_way), 64'd2);
    check("invl_data", 64'(read_data), 64'(DC));

    // Reset suppresses a concurrent fill and discards all entries.
    rst = 1'b1;
    fill(51'h777, DA, DB, DC, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    look(52'hEEE);
    check("rst_fill_drop", 64'(read_hit), 64'd0);
    look(52'h246);
    check("rst_clear_a", 64'(read_hit), 64'd0);
    look(52'd11 << 5);
    check("rst_clear_b", 64'(read_hit), 64'd0);
    check("rst_clear_d", 64'(read_data), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dtlb.md
DTLB -- requirements
Module: dtlb

Interface
REQ-001 Parameter DATA_WIDTH, default 36, width of one page-translation word.
REQ-002 Parameter IP_WIDTH, default 52, width of the lookup key.
REQ-003 Signal clk, input, 1 bit, clock; all state updates on the rising edge.
REQ-004 Signal rst, input, 1 bit, reset: synchronous, active-high.
REQ-005 Signal read_clkEn, input, 1 bit, lookup enable.
REQ-006 Signal sec_wren, input, 1 bit, security-range pass from the AGU; 0 blocks the lookup.
REQ-007 Signal addr, input, IP_WIDTH bits, lookup key {proc[20:0], vaddr[43:13]}.
- addr[0] selects even/odd 8 KB page.
- addr[51:1] is the page-pair address.
REQ-008 Signal sproc, input, 21 bits, space modifier XORed into addr[51:31] before matching.
REQ-009 Signal read_data, output, DATA_WIDTH bits, translation word of the addressed page.
REQ-010 Signal read_data_next, output, DATA_WIDTH bits, translation word of the following page.
REQ-011 Signal read_way, output, 3 bits, encoded hit way.
REQ-012 Signal read_hit, output, 1 bit, lookup hit.
REQ-013 Signal write_addr, input, IP_WIDTH-1 bits, page-pair key to fill.
REQ-014 Signals write_data0/1/2, input, DATA_WIDTH bits each:
- data0: even page.
- data1: odd page.
- data2: even page of the next pair.
REQ-015 Signal force_way, input, 3 bits, victim way when force_way_en=1.
REQ-016 Signal force_way_en, input, 1 bit, use force_way instead of replacement.
REQ-017 Signal write_xstant, input, 1 bit, fill does not advance the replacement pointer.
REQ-018 Signal write_invl, input, 1 bit, invalidate other matching ways during the fill.
REQ-019 Signal write_wen, input, 1 bit, fill strobe.
REQ-020 Translation word layout:
- [30:0] phys (PA[43:13]).
- [31] na (present/accessible).
- [32] wp (write-protect).
- [33] sys (supervisor only).
- [35:34] type.

Function
REQ-021 Organisation: 16 sets x 8 ways; set index = key[4:1]; tag = key[51:5]; each entry = valid, tag, data0, data1, data2.
REQ-022 Lookup is combinational (zero latency). Key K = {addr[51:31]^sproc, addr[30:0]}.
REQ-023 read_hit = read_clkEn & sec_wren & (some valid way in set K[4:1] has tag K[51:5]).
REQ-024 On multiple matching ways, the lowest-numbered way wins; read_way gives its number, else 0.
REQ-025 Data selection on a hit:
- addr[0]=0: read_data = data0, read_data_next = data1.
- addr[0]=1: read_data = data1, read_data_next = data2.
REQ-026 On a miss, read_data and read_data_next are 0.
REQ-027 Fill occurs on a rising edge with write_wen=1; target set = write_addr[3:0], tag = write_addr[50:4].
REQ-028 Victim selection:
- force_way_en=1: force_way.
- Otherwise, a valid way whose tag already matches (lowest such).
- Otherwise, the set's 3-bit round-robin pointer.
REQ-029 The victim way gets valid=1, the new tag and all three data words.
REQ-030 The round-robin pointer increments modulo 8 only when the pointer way was used and write_xstant=0.
REQ-031 With write_invl=1, every other valid way in the set matching the tag is cleared in the same edge.
REQ-032 Simultaneous fill and lookup of the same entry: the lookup returns pre-fill contents that cycle; new contents are visible from the next cycle.
REQ-033 No stalls and no handshake; a write is accepted every cycle.

Reset
REQ-034 rst=1 on an edge clears all valid bits and set pointers to 0 and suppresses any fill that cycle.
REQ-035 After reset, read_hit=0, read_way=0, read_data=0, read_data_next=0.
REQ-036 Reset mid-operation discards all entries.

Verification
REQ-037 Reset, then lookup of any addr with read_clkEn=1, sec_wren=1 -> read_hit=0, read_data=0.
REQ-038 Fill write_addr=51'h123 with data0=A, data1=B, data2=C, no force; next cycle lookup addr=52'h246 -> hit, read_data=A, read_data_next=B; addr=52'h247 -> read_data=B, read_data_next=C, read_way=0.
REQ-039 Same entry with sec_wren=0 or read_clkEn=0 -> read_hit=0; with sproc=1 and addr unchanged -> miss.
REQ-040 Nine fills of distinct tags into set 0, no force -> pointer wraps, the first entry is evicted (miss), the other 8 hit.
REQ-041 Forced fill to way 5 with write_xstant=1 -> hit with read_way=5; pointer unchanged (next unforced fill of a new tag lands in the prior pointer way).
REQ-042 Refill of an existing tag with new data -> same way overwritten, no duplicate; write_invl=1 with forced way 2 over a tag in way 0 -> way 0 invalid, hit on way 2.
